// File: rtl/pvt_pkg.sv
// Shared types and default sizes for the PVT ring-oscillator frequency counter.
package pvt_pkg;

    typedef enum logic [1:0] {
        PVT_IDLE   = 2'd0,
        PVT_SETTLE = 2'd1,
        PVT_GATE   = 2'd2,
        PVT_HOLD   = 2'd3
    } pvt_cnt_state_t;

    localparam int PVT_SETTLE_CYCLES = 4;
    localparam int PVT_CNT_W         = 16;
    localparam int PVT_GATE_LOG2     = 10;
    localparam int PVT_N_OSC         = 4;
    localparam int PVT_SEL_W         = 2;

endpackage

// File: rtl/pvt_sync_edge.sv
// Two-flop synchroniser for an asynchronous oscillator tap, followed by a
// delay flop and a registered single-cycle rising-edge pulse.
module pvt_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic sync_d_r;
    logic rise_r;

    // Synchroniser chain and edge pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            sync_d_r <= 1'b0;
            rise_r   <= 1'b0;
        end else begin
            sync1_r  <= din;
            sync2_r  <= sync1_r;
            sync_d_r <= sync2_r;
            rise_r   <= sync2_r & ~sync_d_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/pvt_osc_counter.sv
// Gated edge counter for the PVT monitor ring oscillators with valid/ready result delivery.
// Optional running min/max of delivered results when PVT_MINMAX_EN is defined.
module pvt_osc_counter
    import pvt_pkg::*;
#(
    parameter int N_OSC     = PVT_N_OSC,
    parameter int SEL_W     = PVT_SEL_W,
    parameter int CNT_W     = PVT_CNT_W,
    parameter int GATE_LOG2 = PVT_GATE_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_OSC-1:0] osc_i,
    input  logic [SEL_W-1:0] sel,
    input  logic             start,
    input  logic             cont,
    input  logic             en,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic [SEL_W-1:0] res_sel,
    output logic             res_ovf
`ifdef PVT_MINMAX_EN
    ,
    input  logic             minmax_clr,
    output logic [CNT_W-1:0] min_data,
    output logic [CNT_W-1:0] max_data
`endif
);

    localparam logic [GATE_LOG2-1:0] SETTLE_LAST = GATE_LOG2'(PVT_SETTLE_CYCLES - 1);
    localparam logic [GATE_LOG2-1:0] GATE_LAST   = {GATE_LOG2{1'b1}};
    localparam logic [GATE_LOG2-1:0] PHASE_ONE   = {{(GATE_LOG2-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    pvt_cnt_state_t       state_r;
    pvt_cnt_state_t       state_nxt_s;
    logic [GATE_LOG2-1:0] phase_cnt_r;
    logic [CNT_W-1:0]     edge_cnt_r;
    logic                 ovf_r;
    logic [SEL_W-1:0]     sel_r;
    logic                 busy_r;
    logic                 valid_r;
    logic                 osc_mux_s;
    logic                 rise_s;
    logic                 launch_s;
    logic                 xfer_s;

    // Saturating increment; the top bit of the result is the overflow flag.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic ovf);
        logic [CNT_W:0] res;
        if (cnt == CNT_MAX) begin
            res = {1'b1, cnt};
        end else begin
            res = {ovf, cnt + CNT_ONE};
        end
        return res;
    endfunction

    // The mux follows the latched select so SETTLE can flush the old tap out of the synchroniser.
    assign osc_mux_s = osc_i[sel_r];

    pvt_sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (osc_mux_s),
        .rise (rise_s)
    );

    assign xfer_s   = valid_r & res_ready;
    assign launch_s = (state_nxt_s == PVT_SETTLE) && (state_r != PVT_SETTLE);

    // Next-state decode; en only aborts while a measurement is running.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PVT_IDLE: begin
                if (en && (start || cont)) state_nxt_s = PVT_SETTLE;
                else                       state_nxt_s = PVT_IDLE;
            end
            PVT_SETTLE: begin
                if (!en)                             state_nxt_s = PVT_IDLE;
                else if (phase_cnt_r == SETTLE_LAST) state_nxt_s = PVT_GATE;
                else                                 state_nxt_s = PVT_SETTLE;
            end
            PVT_GATE: begin
                if (!en)                           state_nxt_s = PVT_IDLE;
                else if (phase_cnt_r == GATE_LAST) state_nxt_s = PVT_HOLD;
                else                               state_nxt_s = PVT_GATE;
            end
            PVT_HOLD: begin
                if (xfer_s) begin
                    if (en && cont) state_nxt_s = PVT_SETTLE;
                    else            state_nxt_s = PVT_IDLE;
                end else begin
                    state_nxt_s = PVT_HOLD;
                end
            end
            default: state_nxt_s = PVT_IDLE;
        endcase
    end

    // State, status flags and phase counter; the phase counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= PVT_IDLE;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            phase_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == PVT_SETTLE) || (state_nxt_s == PVT_GATE);
            valid_r <= (state_nxt_s == PVT_HOLD);
            if (launch_s || (state_nxt_s != state_r)) begin
                phase_cnt_r <= '0;
            end else if ((state_r == PVT_SETTLE) || (state_r == PVT_GATE)) begin
                phase_cnt_r <= phase_cnt_r + PHASE_ONE;
            end else begin
                phase_cnt_r <= phase_cnt_r;
            end
        end
    end

    // Select latch and edge counter; both are frozen outside a launch and GATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r      <= '0;
            edge_cnt_r <= '0;
            ovf_r      <= 1'b0;
        end else if (launch_s) begin
            sel_r      <= sel;
            edge_cnt_r <= '0;
            ovf_r      <= 1'b0;
        end else if ((state_r == PVT_GATE) && rise_s) begin
            sel_r               <= sel_r;
            {ovf_r, edge_cnt_r} <= sat_inc(edge_cnt_r, ovf_r);
        end else begin
            sel_r      <= sel_r;
            edge_cnt_r <= edge_cnt_r;
            ovf_r      <= ovf_r;
        end
    end

    assign busy      = busy_r;
    assign res_valid = valid_r;
    assign res_data  = edge_cnt_r;
    assign res_sel   = sel_r;
    assign res_ovf   = ovf_r;

`ifdef PVT_MINMAX_EN
    logic [CNT_W-1:0] min_r;
    logic [CNT_W-1:0] max_r;

    // Running extremes over results actually handed to the consumer.
    always_ff @(posedge clk) begin
        if (rst || minmax_clr) begin
            min_r <= CNT_MAX;
            max_r <= '0;
        end else if (xfer_s) begin
            if (edge_cnt_r < min_r) min_r <= edge_cnt_r;
            else                    min_r <= min_r;
            if (edge_cnt_r > max_r) max_r <= edge_cnt_r;
            else                    max_r <= max_r;
        end else begin
            min_r <= min_r;
            max_r <= max_r;
        end
    end

    assign min_data = min_r;
    assign max_data = max_r;
`endif

endmodule

// File: tb/tb_pvt_osc_counter.sv
// Randomised self-checking bench for pvt_osc_counter with an edge-window reference model.
module tb_pvt_osc_counter;

    localparam int N_OSC     = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 3;
    localparam int GATE_LOG2 = 4;
    localparam int GATE      = 1 << GATE_LOG2;
    localparam int CMAX      = (1 << CNT_W) - 1;
    localparam int HN        = 16384;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_OSC-1:0] osc_i;
    logic [SEL_W-1:0] sel;
    logic             start;
    logic             cont;
    logic             en;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_data;
    logic [SEL_W-1:0] res_sel;
    logic             res_ovf;
`ifdef PVT_MINMAX_EN
    logic             minmax_clr;
    logic [CNT_W-1:0] min_data;
    logic [CNT_W-1:0] max_data;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [N_OSC-1:0] hist [0:HN-1];
    int per [N_OSC] = '{4, 4, 4, 4};
    int ofs [N_OSC] = '{0, 0, 0, 0};

    pvt_osc_counter #(
        .N_OSC     (N_OSC),
        .SEL_W     (SEL_W),
        .CNT_W     (CNT_W),
        .GATE_LOG2 (GATE_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .osc_i     (osc_i),
        .sel       (sel),
        .start     (start),
        .cont      (cont),
        .en        (en),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sel   (res_sel),
        .res_ovf   (res_ovf)
`ifdef PVT_MINMAX_EN
        ,
        .minmax_clr (minmax_clr),
        .min_data   (min_data),
        .max_data   (max_data)
`endif
    );

    always #5 clk = ~clk;

    // hist[n] holds the tap values the DUT sampled at posedge number n.
    always @(posedge clk) begin
        hist[(cyc + 1) % HN] <= osc_i;
        cyc <= cyc + 1;
    end

    // Oscillator taps: square waves with per-tap period and phase offset, changing on negedges.
    initial begin
        int tick;
        tick  = 0;
        osc_i = '0;
        forever begin
            @(negedge clk);
            tick++;
            for (int j = 0; j < N_OSC; j++)
                osc_i[j] = (((tick + ofs[j]) % per[j]) >= (per[j] / 2));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A start at edge t counts tap rises sampled at edges t+2 .. t+1+GATE, saturated.
    function automatic void model(input int t, input int s, output int cnt, output bit ovf);
        int raw;
        raw = 0;
        for (int k = t + 2; k <= t + 1 + GATE; k++)
            if (hist[k % HN][s] === 1'b1 && hist[(k - 1) % HN][s] === 1'b0) raw++;
        ovf = (raw > CMAX);
        cnt = (raw > CMAX) ? CMAX : raw;
    endfunction

    task automatic pulse_start(input logic [SEL_W-1:0] s, output int t);
        @(negedge clk);
        sel   = s;
        start = 1'b1;
        t     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        sel   = SEL_W'($urandom_range(0, N_OSC - 1));
    endtask

    task automatic wait_valid(output int ve, output bit ok);
        ok = 1'b0;
        ve = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                ve = cyc + 1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_valid: res_valid=%b after 200 cycles, expected 1", res_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; en = 1'b1; cont = 1'b0; sel = 2'd3; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
        if (res_data !== 3'd0)  begin errors++; $display("FAIL reset_data: got %0d expected 0", res_data); end
        if (res_sel !== 2'd0)   begin errors++; $display("FAIL reset_sel: got %0d expected 0", res_sel); end
        if (res_ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %b expected 0", res_ovf); end
        rst = 1'b0; start = 1'b0; res_ready = 1'b0; sel = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b expected 0", busy); end
    endtask

    task automatic test_single();
        int t, ve, ec;
        bit eo, ok;
        logic [SEL_W-1:0] s;
        for (int it = 0; it < 8; it++) begin
            if (it == 0) begin
                per[1] = 4;
                s = 2'd1;
            end else begin
                for (int j = 0; j < N_OSC; j++) begin
                    per[j] = $urandom_range(2, 9);
                    ofs[j] = $urandom_range(0, 8);
                end
                s = SEL_W'($urandom_range(0, N_OSC - 1));
            end
            pulse_start(s, t);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL single_busy it=%0d: got %b expected 1", it, busy); end
            wait_valid(ve, ok);
            if (!ok) return;
            model(t, int'(s), ec, eo);
            checks += 5;
            if (ve != t + 5 + GATE)    begin errors++; $display("FAIL single_latency it=%0d: valid at t+%0d expected t+%0d", it, ve - t, 5 + GATE); end
            if (int'(res_data) !== ec) begin errors++; $display("FAIL single_data it=%0d: got %0d expected %0d", it, res_data, ec); end
            if (res_ovf !== eo)        begin errors++; $display("FAIL single_ovf it=%0d: got %b expected %b", it, res_ovf, eo); end
            if (res_sel !== s)         begin errors++; $display("FAIL single_sel it=%0d: got %0d expected %0d", it, res_sel, s); end
            if (busy !== 1'b0)         begin errors++; $display("FAIL single_hold_busy it=%0d: got %b expected 0", it, busy); end
            if (it == 0) begin
                checks++;
                if (res_data !== 3'd4) begin errors++; $display("FAIL directed_count: got %0d expected 4", res_data); end
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL single_ack it=%0d: valid=%b expected 0", it, res_valid); end
        end
    endtask

    task automatic test_saturate();
        int t, ve;
        bit ok;
        for (int j = 0; j < N_OSC; j++) per[j] = 2;
        pulse_start(2'd2, t);
        wait_valid(ve, ok);
        if (!ok) return;
        checks += 3;
        if (res_data !== 3'd7) begin errors++; $display("FAIL sat_data: got %0d expected 7", res_data); end
        if (res_ovf !== 1'b1)  begin errors++; $display("FAIL sat_ovf: got %b expected 1", res_ovf); end
        if (res_sel !== 2'd2)  begin errors++; $display("FAIL sat_sel: got %0d expected 2", res_sel); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        int t, ve, ec;
        bit eo, ok;
        logic [SEL_W-1:0] s;
        for (int j = 0; j < N_OSC; j++) per[j] = $urandom_range(2, 7);
        s = SEL_W'($urandom_range(0, N_OSC - 1));
        pulse_start(s, t);
        wait_valid(ve, ok);
        if (!ok) return;
        model(t, int'(s), ec, eo);
        for (int i = 0; i <= 10; i++) begin
            checks += 4;
            if (res_valid !== 1'b1)    begin errors++; $display("FAIL stall_valid i=%0d: got %b expected 1", i, res_valid); end
            if (int'(res_data) !== ec) begin errors++; $display("FAIL stall_data i=%0d: got %0d expected %0d", i, res_data, ec); end
            if (res_sel !== s)         begin errors++; $display("FAIL stall_sel i=%0d: got %0d expected %0d", i, res_sel, s); end
            if (res_ovf !== eo)        begin errors++; $display("FAIL stall_ovf i=%0d: got %b expected %b", i, res_ovf, eo); end
            if (i < 10) begin
                start = 1'($urandom_range(0, 1));
                en    = 1'($urandom_range(0, 1));
                sel   = SEL_W'($urandom_range(0, N_OSC - 1));
                @(negedge clk);
            end
        end
        start = 1'b0; en = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks += 2;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_ack_valid: got %b expected 0", res_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL stall_ack_busy: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL stall_idle: busy=%b valid=%b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_back_to_back();
        int t, ve, prev_ve, ec;
        bit eo, ok;
        logic [SEL_W-1:0] s, next_s;
        for (int j = 0; j < N_OSC; j++) begin
            per[j] = $urandom_range(2, 9);
            ofs[j] = $urandom_range(0, 8);
        end
        s = SEL_W'($urandom_range(0, N_OSC - 1));
        res_ready = 1'b1;
        @(negedge clk);
        sel  = s;
        cont = 1'b1;
        t    = cyc + 1;
        prev_ve = 0;
        for (int r = 0; r < 4; r++) begin
            repeat (10) @(negedge clk);
            next_s = SEL_W'($urandom_range(0, N_OSC - 1));
            sel = next_s;
            wait_valid(ve, ok);
            if (!ok) break;
            model(t, int'(s), ec, eo);
            checks += 4;
            if (ve != t + 5 + GATE)    begin errors++; $display("FAIL b2b_latency r=%0d: valid at t+%0d expected t+%0d", r, ve - t, 5 + GATE); end
            if (int'(res_data) !== ec) begin errors++; $display("FAIL b2b_data r=%0d: got %0d expected %0d", r, res_data, ec); end
            if (res_ovf !== eo)        begin errors++; $display("FAIL b2b_ovf r=%0d: got %b expected %b", r, res_ovf, eo); end
            if (res_sel !== s)         begin errors++; $display("FAIL b2b_sel r=%0d: got %0d expected %0d", r, res_sel, s); end
            if (r > 0) begin
                checks++;
                if (ve - prev_ve != GATE + 5) begin errors++; $display("FAIL b2b_spacing r=%0d: got %0d expected %0d", r, ve - prev_ve, GATE + 5); end
            end
            prev_ve = ve;
            t = ve;
            s = next_s;
            if (r == 3) cont = 1'b0;
            @(negedge clk);
            checks += 2;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack r=%0d: valid=%b expected 0", r, res_valid); end
            if (busy !== (r < 3))   begin errors++; $display("FAIL b2b_restart r=%0d: busy=%b expected %b", r, busy, (r < 3)); end
        end
        res_ready = 1'b0;
        cont = 1'b0;
    endtask

    task automatic test_abort();
        int t, ve;
        bit ok, seen;
        pulse_start(2'd1, t);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
        en = 1'b0;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", res_valid); end
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < GATE + 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_result: activity seen=%b expected 0", seen); end
        for (int j = 0; j < N_OSC; j++) per[j] = 2;
        pulse_start(2'd3, t);
        wait_valid(ve, ok);
        if (!ok) return;
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (busy !== 1'b0)      begin errors++; $display("FAIL hold_rst_busy: got %b expected 0", busy); end
        if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_rst_valid: got %b expected 0", res_valid); end
        if (res_data !== 3'd0)  begin errors++; $display("FAIL hold_rst_data: got %0d expected 0", res_data); end
        if (res_sel !== 2'd0)   begin errors++; $display("FAIL hold_rst_sel: got %0d expected 0", res_sel); end
        if (res_ovf !== 1'b0)   begin errors++; $display("FAIL hold_rst_ovf: got %b expected 0", res_ovf); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_rst_discard: valid=%b expected 0", res_valid); end
    endtask

`ifdef PVT_MINMAX_EN
    task automatic test_minmax();
        int pers [3] = '{4, 2, 8};
        int mn, mx, t, ve, ec;
        bit eo, ok;
        mn = CMAX;
        mx = 0;
        @(negedge clk); minmax_clr = 1'b1;
        @(negedge clk); minmax_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < N_OSC; j++) per[j] = pers[i];
            pulse_start(2'd1, t);
            wait_valid(ve, ok);
            if (!ok) return;
            model(t, 1, ec, eo);
            if (ec < mn) mn = ec;
            if (ec > mx) mx = ec;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        @(negedge clk);
        checks += 2;
        if (int'(min_data) !== mn) begin errors++; $display("FAIL minmax_min: got %0d expected %0d", min_data, mn); end
        if (int'(max_data) !== mx) begin errors++; $display("FAIL minmax_max: got %0d expected %0d", max_data, mx); end
        minmax_clr = 1'b1;
        @(negedge clk);
        minmax_clr = 1'b0;
        checks += 2;
        if (int'(min_data) !== CMAX) begin errors++; $display("FAIL minmax_clr_min: got %0d expected %0d", min_data, CMAX); end
        if (max_data !== 3'd0)       begin errors++; $display("FAIL minmax_clr_max: got %0d expected 0", max_data); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; en = 1'b1; sel = '0; res_ready = 1'b0;
`ifdef PVT_MINMAX_EN
        minmax_clr = 1'b0;
`endif
        test_reset();
        test_single();
        test_saturate();
        test_hold_stall();
        test_back_to_back();
        test_abort();
`ifdef PVT_MINMAX_EN
        test_minmax();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pvt_osc_counter.md
# pvt_osc_counter

Gated frequency counter for the PVT monitor's ring oscillators. It selects one of N asynchronous oscillator taps, synchronises it into the `clk` domain and counts its rising edges over a fixed gate window of 2^GATE_LOG2 clock cycles. It sits directly upstream of the readout/output logic of the monitor top and delivers each count through a valid/ready handshake.

## Interface
- `N_OSC`, 4: number of oscillator inputs, ≥2.
- `SEL_W`, 2: select width, equal to clog2(N_OSC).
- `CNT_W`, 16: result width.
- `GATE_LOG2`, 10: gate window length is 2^GATE_LOG2 clk cycles, range 2..20.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `osc_i`  in  N_OSC  asynchronous oscillator taps.
- `sel`  in  SEL_W  oscillator select, latched on start.
- `start`  in  1  single-cycle request for one measurement.
- `cont`  in  1  continuous mode: restart automatically after each handshake.
- `en`  in  1  block enable; low aborts a measurement in progress.
- `busy`  out  1  high in SETTLE or GATE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  CNT_W  edge count.
- `res_sel`  out  SEL_W  oscillator the result belongs to.
- `res_ovf`  out  1  count saturated.

## Operation
- States: IDLE, SETTLE, GATE, HOLD.
- IDLE → SETTLE when `en & (start | cont)`. `sel` is latched into `res_sel`, and the edge counter and gate counter are cleared.
- SETTLE lasts exactly 4 cycles. Edges seen during SETTLE are ignored, which flushes the synchroniser after a mux change. Then → GATE.
- GATE lasts exactly 2^GATE_LOG2 cycles. On each cycle where the synchronised tap shows a rising edge, the edge counter increments.
  - The counter saturates at 2^CNT_W−1 and sets `res_ovf`. It does not wrap.
  - After the last GATE cycle → HOLD.
- HOLD:
  - `res_valid` = 1. `res_data`, `res_sel` and `res_ovf` are stable until handshake.
  - On `res_valid & res_ready`: go to SETTLE if `en & cont`, otherwise IDLE.
- `en` low in SETTLE or GATE → IDLE next cycle. No result is produced.
- `en` low in HOLD has no effect: the held result is still delivered.
- `start` outside IDLE is ignored. `sel` changes outside IDLE are ignored.
- Edge detect: a 2-flop synchroniser followed by a delay flop, with rise = `s & ~s_d`. Measurable frequency is < clk/2; faster taps are prescaled upstream.
- Reset:
  - All outputs are 0, state = IDLE, and all counters and synchroniser flops are cleared.
  - Reset in any state, including HOLD, discards the result.

## Timing
- `start` sampled high at edge t:
  - SETTLE occupies cycles t+1..t+4.
  - GATE occupies cycles t+5..t+4+2^GATE_LOG2.
  - `res_valid` rises at t+5+2^GATE_LOG2.
- Synchroniser latency: an `osc_i` rising edge is counted 3 cycles after it is sampled. Edges sampled in the last 3 GATE cycles are not counted.
- `res_valid` and `res_ready` both high at edge h: transfer completes.
  - `res_valid` = 0 at h+1.
  - In continuous mode, SETTLE starts at h+1 and the next result is valid at h+5+2^GATE_LOG2.
- `busy` is registered and tracks state with no extra delay.
- All outputs are registered. No combinational path from `res_ready` to any output.

## Configuration
- `PVT_MINMAX_EN` defined:
  - Adds outputs `min_data` and `max_data` (CNT_W each) and input `minmax_clr`.
  - On each completed handshake, the running min and max of `res_data` are updated.
  - Reset or `minmax_clr` sets min = all-ones and max = 0.
- `PVT_MINMAX_EN` undefined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- Shared package `pvt_pkg` holds:
  - the state enum `pvt_cnt_state_t`;
  - the constant `PVT_SETTLE_CYCLES` = 4;
  - the default widths `PVT_CNT_W` and `PVT_GATE_LOG2`.
- One sub-module, `pvt_sync_edge`: the 2-flop synchroniser plus rising-edge detector, instantiated once after the select mux.

## Test plan
- GATE_LOG2=4, `sel`=1, `osc_i[1]` period 4 clk, pulse `start` → `res_valid` at t+21, `res_data`=4, `res_sel`=1, `res_ovf`=0.
- CNT_W=3, osc period 2 clk, GATE_LOG2=4 → `res_data`=7, `res_ovf`=1.
- `res_ready` held low for 10 cycles after valid → `res_valid` and `res_data` stable throughout. Then assert ready for 1 cycle → `res_valid`=0 the next cycle, state IDLE.
- `cont`=1, `res_ready`=1 always → back-to-back results spaced exactly 2^GATE_LOG2+5 cycles apart. `sel` changes mid-GATE are reflected only in the next result's `res_sel`.
- `en` dropped at GATE cycle 3 → IDLE next cycle, no `res_valid`. Then `rst` asserted in HOLD → all outputs 0 on the next cycle.
- With `PVT_MINMAX_EN`: results 5, 9, 3 → `min_data`=3, `max_data`=9. Then `minmax_clr` → `min_data`=all-ones, `max_data`=0.
